// File: rtl/dtc_rx.sv
// dtc_rx: DTC link receiver, aligns nibbles to sync words and decodes reply/status/event frames
module dtc_rx #(
  parameter logic [15:0] SYNC_WORD  = 16'hBC50,
  parameter logic [15:0] REPLY_HDR  = 16'hF7F7,
  parameter logic [15:0] STATUS_HDR = 16'hDCDC,
  parameter logic [15:0] EVENT_HDR  = 16'h5C5C,
  parameter logic [15:0] TRAILER    = 16'hC5D5,
  parameter int          N_CH       = 64,
  parameter int          EVT_WINDOW = 40,
  parameter int          SYNC_LOCK  = 4
) (
  input  logic        dtc_clk,
  input  logic        rst_n,
  input  logic [3:0]  dtc_nibble,
  output logic        locked,
  output logic        reply_vld,
  output logic [31:0] reply_addr,
  output logic [31:0] reply_data,
  output logic        status_vld,
  output logic [15:0] status_word,
  output logic        evt_start,
  output logic        adc_vld,
  output logic [11:0] adc_data,
  output logic [5:0]  adc_ch,
  output logic [5:0]  adc_sample,
  output logic        evt_done,
  output logic        frame_err
);
  typedef enum logic [3:0] {
    HUNT, IDLE, R_AH, R_AL, R_DH, R_DL, STAT, EVT_ADC, EVT_TDC, EVT_TRL, EVT_SWL
  } state_t;
  state_t      st;
  logic [15:0] sr;
  logic [1:0]  ph;
  logic [2:0]  cnt;
  logic [5:0]  ch, smp;
  logic [47:0] rtmp;
  logic        bnd, trl_bad, redecode;
  assign bnd      = ph == 2'd0;
  assign trl_bad  = st == EVT_TRL && sr != TRAILER;
  assign redecode = st == IDLE || trl_bad || (st == EVT_SWL && sr != TRAILER);
  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= HUNT;
      sr          <= '0;
      ph          <= '0;
      cnt         <= '0;
      ch          <= '0;
      smp         <= '0;
      rtmp        <= '0;
      locked      <= 1'b0;
      reply_vld   <= 1'b0;
      reply_addr  <= '0;
      reply_data  <= '0;
      status_vld  <= 1'b0;
      status_word <= '0;
      evt_start   <= 1'b0;
      adc_vld     <= 1'b0;
      adc_data    <= '0;
      adc_ch      <= '0;
      adc_sample  <= '0;
      evt_done    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sr         <= {dtc_nibble, sr[15:4]};
      ph         <= ph + 2'd1;
      reply_vld  <= 1'b0;
      status_vld <= 1'b0;
      evt_start  <= 1'b0;
      adc_vld    <= 1'b0;
      evt_done   <= 1'b0;
      frame_err  <= 1'b0;
      if (st == HUNT) begin
        if (sr == SYNC_WORD && (cnt == 3'd0 || bnd)) begin
          ph <= 2'd1;
          if (cnt == 3'(SYNC_LOCK - 1)) begin
            st     <= IDLE;
            locked <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end else if (bnd) begin
          cnt <= '0;
        end
      end else if (bnd) begin
        if (redecode) begin
          if (trl_bad) frame_err <= 1'b1;
          if (sr == SYNC_WORD) st <= IDLE;
          else if (sr == REPLY_HDR) st <= R_AH;
          else if (sr == STATUS_HDR) st <= STAT;
          else if (sr == EVENT_HDR) begin
            st        <= EVT_ADC;
            evt_start <= 1'b1;
            ch        <= 6'(N_CH - 1);
            smp       <= 6'(EVT_WINDOW - 1);
          end else begin
            frame_err <= 1'b1;
            locked    <= 1'b0;
            cnt       <= '0;
            st        <= HUNT;
          end
        end else begin
          case (st)
            R_AH: begin
              rtmp[47:32] <= sr;
              st          <= R_AL;
            end
            R_AL: begin
              rtmp[31:16] <= sr;
              st          <= R_DH;
            end
            R_DH: begin
              rtmp[15:0] <= sr;
              st         <= R_DL;
            end
            R_DL: begin
              reply_addr <= rtmp[47:16];
              reply_data <= {rtmp[15:0], sr};
              reply_vld  <= 1'b1;
              st         <= IDLE;
            end
            STAT: begin
              status_word <= sr;
              status_vld  <= 1'b1;
              st          <= IDLE;
            end
            EVT_ADC: begin
              if (sr[15:12] != 4'd0) begin
                frame_err <= 1'b1;
                st        <= IDLE;
              end else begin
                adc_vld    <= 1'b1;
                adc_data   <= sr[11:0];
                adc_ch     <= ch;
                adc_sample <= smp;
                if (smp == 6'd0) begin
                  smp <= 6'(EVT_WINDOW - 1);
                  if (ch == 6'd0) st <= EVT_TDC;
                  else ch <= ch - 6'd1;
                end else begin
                  smp <= smp - 6'd1;
                end
              end
            end
            EVT_TDC: st <= EVT_TRL;
            EVT_TRL: begin
              evt_done <= 1'b1;
              st       <= EVT_SWL;
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_dtc_rx.sv
// tb_dtc_rx: word-level protocol model and per-cycle comparison against dtc_rx
module tb_dtc_rx;
  logic        dtc_clk = 0, rst_n = 0;
  logic [3:0]  dtc_nibble = 0;
  logic        locked, reply_vld, status_vld, evt_start, adc_vld, evt_done, frame_err;
  logic [31:0] reply_addr, reply_data;
  logic [15:0] status_word;
  logic [11:0] adc_data;
  logic [5:0]  adc_ch, adc_sample;

  dtc_rx dut (
    .dtc_clk(dtc_clk), .rst_n(rst_n), .dtc_nibble(dtc_nibble), .locked(locked),
    .reply_vld(reply_vld), .reply_addr(reply_addr), .reply_data(reply_data),
    .status_vld(status_vld), .status_word(status_word), .evt_start(evt_start),
    .adc_vld(adc_vld), .adc_data(adc_data), .adc_ch(adc_ch), .adc_sample(adc_sample),
    .evt_done(evt_done), .frame_err(frame_err)
  );

  always #5 dtc_clk = ~dtc_clk;

  typedef struct {
    logic rv; logic [31:0] ra, rd; logic sv; logic [15:0] sw;
    logic es, av; logic [11:0] ad; logic [5:0] ac, asm;
    logic ed, fe, lk;
  } exp_t;

  int total, bad, pc;
  exp_t exq[int];
  exp_t ce, m_e;
  logic c_lk, p_lk;
  int n_rv, n_sv, n_es, n_av, n_ed, n_fe, rise_pc;
  logic [31:0] l_ra, l_rd;
  logic [15:0] l_sw;
  logic [11:0] l_ad;
  logic [5:0]  l_ac, l_as;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endfunction

  // Word-level model: state is the protocol phase, ADC position is a flat sample index
  typedef enum {M_HUNT, M_IDLE, M_REPLY, M_STAT, M_ADC, M_TDC, M_TRL, M_SWL} mst_t;
  mst_t m_st = M_HUNT;
  int m_sc, m_k;
  logic m_lk;
  logic [15:0] m_rq[$];

  function automatic void m_reset();
    m_st = M_HUNT; m_sc = 0; m_k = 0; m_lk = 0; m_rq.delete();
  endfunction

  function automatic void m_dispatch(input logic [15:0] w);
    case (w)
      16'hBC50: m_st = M_IDLE;
      16'hF7F7: m_st = M_REPLY;
      16'hDCDC: m_st = M_STAT;
      16'h5C5C: begin m_st = M_ADC; m_k = 0; m_e.es = 1; end
      default: begin m_e.fe = 1; m_lk = 0; m_sc = 0; m_st = M_HUNT; end
    endcase
  endfunction

  function automatic void m_word(input logic [15:0] w);
    m_e = '{default: '0};
    case (m_st)
      M_HUNT: if (w == 16'hBC50) begin
        m_sc++;
        if (m_sc == 4) begin m_lk = 1; m_st = M_IDLE; m_sc = 0; end
      end else m_sc = 0;
      M_IDLE: m_dispatch(w);
      M_REPLY: begin
        m_rq.push_back(w);
        if (m_rq.size() == 4) begin
          m_e.rv = 1; m_e.ra = {m_rq[0], m_rq[1]}; m_e.rd = {m_rq[2], m_rq[3]};
          m_rq.delete(); m_st = M_IDLE;
        end
      end
      M_STAT: begin m_e.sv = 1; m_e.sw = w; m_st = M_IDLE; end
      M_ADC: if (w[15:12] != 0) begin m_e.fe = 1; m_st = M_IDLE; end
      else begin
        m_e.av = 1; m_e.ad = w[11:0];
        m_e.ac = 6'(63 - m_k / 40); m_e.asm = 6'(39 - m_k % 40);
        m_k++;
        if (m_k == 64 * 40) m_st = M_TDC;
      end
      M_TDC: m_st = M_TRL;
      M_TRL: if (w == 16'hC5D5) begin m_e.ed = 1; m_st = M_SWL; end
      else begin m_e.fe = 1; m_dispatch(w); end
      M_SWL: if (w != 16'hC5D5) m_dispatch(w);
    endcase
    m_e.lk = m_lk;
  endfunction

  always @(posedge dtc_clk) pc++;

  always @(negedge dtc_clk) begin
    ce = '{default: '0};
    if (!rst_n) c_lk = 0;
    else if (exq.exists(pc)) begin ce = exq[pc]; exq.delete(pc); c_lk = ce.lk; end
    ce.lk = c_lk;
    chk("locked", locked, ce.lk);
    chk("reply_vld", reply_vld, ce.rv);
    chk("status_vld", status_vld, ce.sv);
    chk("evt_start", evt_start, ce.es);
    chk("adc_vld", adc_vld, ce.av);
    chk("evt_done", evt_done, ce.ed);
    chk("frame_err", frame_err, ce.fe);
    if (ce.rv) begin chk("reply_addr", reply_addr, ce.ra); chk("reply_data", reply_data, ce.rd); end
    if (ce.sv) chk("status_word", status_word, ce.sw);
    if (ce.av) begin
      chk("adc_data", adc_data, ce.ad);
      chk("adc_ch", adc_ch, ce.ac);
      chk("adc_sample", adc_sample, ce.asm);
    end
    if (reply_vld) begin n_rv++; l_ra = reply_addr; l_rd = reply_data; end
    if (status_vld) begin n_sv++; l_sw = status_word; end
    if (adc_vld) begin n_av++; l_ad = adc_data; l_ac = adc_ch; l_as = adc_sample; end
    if (evt_start) n_es++;
    if (evt_done) n_ed++;
    if (frame_err) n_fe++;
    if (locked && !p_lk) rise_pc = pc;
    p_lk = locked;
  end

  task automatic send_word(input logic [15:0] w, output int key);
    for (int i = 0; i < 4; i++) begin
      @(negedge dtc_clk);
      dtc_nibble = w[4*i +: 4];
    end
    key = pc + 2;
    m_word(w);
    exq[key] = m_e;
  endtask

  task automatic sw(input logic [15:0] w);
    int k;
    send_word(w, k);
  endtask

  task automatic nib(input logic [3:0] n);
    @(negedge dtc_clk);
    dtc_nibble = n;
  endtask

  task automatic adc_words(input int n);
    for (int k = 0; k < n; k++) sw(16'((63 - k / 40) * 64 + (39 - k % 40)));
  endtask

  task automatic reset_dut();
    @(negedge dtc_clk);
    #2;
    rst_n = 0;
    exq.delete();
    m_reset();
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_strobes", {reply_vld, status_vld, evt_start, adc_vld, evt_done, frame_err}, 0);
    chk("rst_reply", reply_addr | reply_data, 0);
    chk("rst_status", status_word, 0);
    chk("rst_adc", {adc_data, adc_ch, adc_sample}, 0);
    repeat (2) @(negedge dtc_clk);
    #2;
    rst_n = 1;
  endtask

  int key, b_rv, b_sv, b_es, b_av, b_ed, b_fe;

  task automatic snap();
    b_rv = n_rv; b_sv = n_sv; b_es = n_es; b_av = n_av; b_ed = n_ed; b_fe = n_fe;
  endtask

  initial begin
    // Lock at every nibble offset: locked rises exactly at the 4th sync's decode
    for (int off = 0; off < 4; off++) begin
      reset_dut();
      repeat (off) nib(4'h0);
      repeat (3) sw(16'hBC50);
      send_word(16'hBC50, key);
      sw(16'hBC50); sw(16'hBC50);
      chk("lock_cycle", rise_pc, key);
      chk("locked_after", locked, 1);
    end
    // Reply frames, including header values carried as payload
    snap();
    sw(16'hF7F7); sw(16'h1234); sw(16'h5678); sw(16'h9ABC); sw(16'hDEF0);
    sw(16'hBC50); sw(16'hBC50);
    chk("reply_cnt", n_rv - b_rv, 1);
    chk("reply_addr_lit", l_ra, 32'h12345678);
    chk("reply_data_lit", l_rd, 32'h9ABCDEF0);
    chk("reply_locked", locked, 1);
    sw(16'hF7F7); sw(16'hBC50); sw(16'h5C5C); sw(16'hDCDC); sw(16'hF7F7);
    sw(16'hBC50); sw(16'hBC50);
    chk("reply2_addr", l_ra, 32'hBC505C5C);
    chk("reply2_data", l_rd, 32'hDCDCF7F7);
    chk("reply_nofe", n_fe - b_fe, 0);
    // Status frame
    snap();
    sw(16'hDCDC); sw(16'h00A5); sw(16'hBC50); sw(16'hBC50);
    chk("status_cnt", n_sv - b_sv, 1);
    chk("status_lit", l_sw, 16'h00A5);
    // Full event with repeated trailers
    snap();
    sw(16'h5C5C);
    adc_words(2560);
    sw(16'h0000);
    repeat (4) sw(16'hC5D5);
    sw(16'hBC50); sw(16'hBC50); sw(16'hBC50);
    chk("evt_start_cnt", n_es - b_es, 1);
    chk("adc_cnt", n_av - b_av, 2560);
    chk("evt_done_cnt", n_ed - b_ed, 1);
    chk("evt_nofe", n_fe - b_fe, 0);
    chk("adc_last", {l_ad, l_ac, l_as}, 0);
    chk("evt_locked", locked, 1);
    // Bad IDLE word unlocks; relock; bad ADC word returns to IDLE still locked
    snap();
    sw(16'hBC50); sw(16'h1234); sw(16'hBC50);
    chk("unlock", locked, 0);
    repeat (4) sw(16'hBC50);
    sw(16'hBC50);
    chk("relock", locked, 1);
    sw(16'h5C5C);
    adc_words(3);
    sw(16'h8001);
    sw(16'hBC50); sw(16'hBC50);
    chk("err_fe_cnt", n_fe - b_fe, 2);
    chk("err_adc_cnt", n_av - b_av, 3);
    chk("err_locked", locked, 1);
    // Reset in the middle of an event, then relock at a new offset
    snap();
    sw(16'h5C5C);
    adc_words(100);
    reset_dut();
    nib(4'h0); nib(4'h0);
    repeat (4) sw(16'hBC50);
    sw(16'hDCDC); sw(16'h0042); sw(16'hBC50); sw(16'hBC50);
    chk("rst_no_done", n_ed - b_ed, 0);
    chk("rst_status_cnt", n_sv - b_sv, 1);
    chk("rst_status_lit", l_sw, 16'h0042);
    chk("rst_relock", locked, 1);
    repeat (4) @(negedge dtc_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
